// File: rtl/s_axi_regfile.sv
// Single-beat AXI4 slave register file with per-register read-only status slots.
// Write and read channels run independent FSMs; regs_o is driven purely from flops.
module s_axi_regfile #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          NUM_REGS = 8,
  parameter int unsigned          ID_W     = 4,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            awid_i,
  input  logic [ADDR_W-1:0]          awaddr_i,
  input  logic                       awvalid_i,
  output logic                       awready_o,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  output logic [ID_W-1:0]            bid_o,
  output logic [1:0]                 bresp_o,
  output logic                       bvalid_o,
  input  logic                       bready_i,
  input  logic [ID_W-1:0]            arid_i,
  input  logic [ADDR_W-1:0]          araddr_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_W-1:0]            rid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} wr_state_e;
  typedef enum logic {RIdle, RData} rd_state_e;

  wr_state_e           wr_state_q, wr_state_d;
  rd_state_e           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ID_W-1:0]     awid_q, awid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                commit;
  logic [ADDR_W-1:0]   c_addr;
  logic [ID_W-1:0]     c_id;
  logic [DATA_W-1:0]   c_data;
  logic [StrbW-1:0]    c_strb;
  logic [IdxW-1:0]     c_idx;
  logic [IdxW-1:0]     r_idx;

  // Only RO slices of hw_status_i are consumed, and wlast is meaningless for single beats.
  logic unused_in;
  assign unused_in = ^{wlast_i, hw_status_i};

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IdxW'(a >> OffW);
  endfunction

  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return (a >> (OffW + IdxW)) != '0;
  endfunction

  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    awid_d     = awid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    awready_o  = 1'b0;
    wready_o   = 1'b0;
    commit     = 1'b0;
    c_addr     = awaddr_q;
    c_id       = awid_q;
    c_data     = wdata_q;
    c_strb     = wstrb_q;

    unique case (wr_state_q)
      WIdle: begin
        awready_o = 1'b1;
        wready_o  = 1'b1;
        if (awvalid_i && wvalid_i) begin
          commit = 1'b1;
          c_addr = awaddr_i;
          c_id   = awid_i;
          c_data = wdata_i;
          c_strb = wstrb_i;
        end else if (awvalid_i) begin
          awaddr_d   = awaddr_i;
          awid_d     = awid_i;
          wr_state_d = WHaveAw;
        end else if (wvalid_i) begin
          wdata_d    = wdata_i;
          wstrb_d    = wstrb_i;
          wr_state_d = WHaveW;
        end
      end
      WHaveAw: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          commit = 1'b1;
          c_data = wdata_i;
          c_strb = wstrb_i;
        end
      end
      WHaveW: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          commit = 1'b1;
          c_addr = awaddr_i;
          c_id   = awid_i;
        end
      end
      WResp: begin
        if (bready_i) wr_state_d = WIdle;
      end
      default: wr_state_d = WIdle;
    endcase

    c_idx = addr_idx(c_addr);
    if (commit) begin
      wr_state_d = WResp;
      bid_d      = c_id;
      if (!addr_oob(c_addr) && !RO_MASK[c_idx]) begin
        bresp_d = RespOkay;
        for (int unsigned b = 0; b < StrbW; b++) begin
          if (c_strb[b]) regs_d[c_idx][b*8 +: 8] = c_data[b*8 +: 8];
        end
      end else begin
        bresp_d = RespSlvErr;
      end
    end

    // Status registers track hardware every cycle regardless of AXI traffic.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) regs_d[i] = hw_status_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    arready_o  = (rd_state_q == RIdle);
    r_idx      = addr_idx(araddr_i);

    unique case (rd_state_q)
      RIdle: begin
        if (arvalid_i) begin
          rd_state_d = RData;
          rid_d      = arid_i;
          if (addr_oob(araddr_i)) begin
            rresp_d = RespSlvErr;
            rdata_d = '0;
          end else begin
            rresp_d = RespOkay;
            rdata_d = regs_q[r_idx];
          end
        end
      end
      RData: begin
        if (rready_i) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      awaddr_q   <= '0;
      awid_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bid_q      <= '0;
      bresp_q    <= '0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      awid_q     <= awid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bvalid_o = (wr_state_q == WResp);
  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = (rd_state_q == RData);
  assign rlast_o  = rvalid_o;
  assign rid_o    = rid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: doc/s_axi_regfile.md
Name: s_axi_regfile

Overview:
- Parametrised single-beat AXI4 slave register file; the next generation of the team's fixed 8x32 AXI register block.
- Generalises data width, register count and ID width.
- Adds per-register read-only (hardware status) mode, decoded SLVERR responses and ID echo on B and R.
- Sits between the AXI interconnect and counter/control logic: exposes all register contents and accepts hardware status values.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- NUM_REGS, 8, number of registers; power of two, >= 2.
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI address width.
- RO_MASK, 0, NUM_REGS-bit mask; bit i set makes reg i read-only from AXI and sourced from hw_status_i.

Ports:
- clk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous reset, active-high
- awid_i  in  ID_W  write address ID
- awaddr_i  in  ADDR_W  write byte address
- awvalid_i  in  1  write address valid
- awready_o  out  1  write address ready
- wdata_i  in  DATA_W  write data
- wstrb_i  in  DATA_W/8  byte strobes
- wlast_i  in  1  ignored (single-beat only)
- wvalid_i  in  1  write data valid
- wready_o  out  1  write data ready
- bid_o  out  ID_W  response ID (= captured awid)
- bresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- bvalid_o  out  1  write response valid
- bready_i  in  1  write response ready
- arid_i  in  ID_W  read address ID
- araddr_i  in  ADDR_W  read byte address
- arvalid_i  in  1  read address valid
- arready_o  out  1  read address ready
- rid_o  out  ID_W  read ID (= captured arid)
- rdata_o  out  DATA_W  read data
- rresp_o  out  2  OKAY/SLVERR
- rlast_o  out  1  equals rvalid_o
- rvalid_o  out  1  read data valid
- rready_i  in  1  read data ready
- hw_status_i  in  NUM_REGS*DATA_W  hw values for RO registers; slice i = reg i
- regs_o  out  NUM_REGS*DATA_W  current contents of all registers, flattened

Behaviour:
- Decode: index = addr[$clog2(NUM_REGS)+$clog2(DATA_W/8)-1 : $clog2(DATA_W/8)]. Address is out of range if any higher address bit is set. Low byte-offset bits are ignored.
- Reset (areset=1 at a clk edge): all writable regs = 0; awready_o=wready_o=arready_o=1; bvalid_o=rvalid_o=rlast_o=0; bid_o=rid_o=0; bresp_o=rresp_o=0; rdata_o=0; address/data holding flags cleared. Reset mid-transaction drops the transaction silently.
- RO registers: each cycle, reg i <= hw_status_i slice i. They never take AXI writes.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: awready=wready=1. AW handshake alone -> HAVE_AW, capturing addr/id. W handshake alone -> HAVE_W, capturing data/strb. Both in the same cycle -> commit.
  - HAVE_AW: awready=0, wready=1. W handshake -> commit.
  - HAVE_W: wready=0, awready=1. AW handshake -> commit.
  - Commit (same edge as completing handshake): in range and writable -> byte lanes with strb=1 are updated, bresp=OKAY. Out of range or RO -> no update, bresp=SLVERR. bvalid_o=1 next cycle, bid_o = captured ID. Go to RESP.
  - RESP: awready=wready=0; bvalid/bid/bresp held stable until bready_i=1, then IDLE next cycle.
  - Write latency: completing handshake at edge N -> register updated and bvalid_o high after edge N.
- Read FSM states: IDLE, RDATA.
  - IDLE: arready=1. AR handshake at edge N -> rvalid_o, rlast_o=1 after edge N. rdata = register value before edge N (a write committing at the same edge is not visible). rid = arid. rresp=SLVERR with rdata=0 if out of range. Go to RDATA.
  - RDATA: arready=0; R outputs held stable until rready_i=1, then IDLE next cycle (arready=1).
- Read and write channels are independent; simultaneous operations never stall each other.
- regs_o reflects register contents after each edge (zero combinational path from AXI inputs).

Test Plan:
- Reset then AW(id=3, addr=0x08) and W(data=0xDEADBEEF, strb=0xF) in the same cycle, bready=1 -> next cycle bvalid=1, bid=3, bresp=00, regs_o reg2=0xDEADBEEF; AR(id=5, addr=0x08) -> rvalid=1, rid=5, rdata=0xDEADBEEF, rlast=1.
- W before AW by 3 cycles, strb=0x5, data=0x11223344 onto reg1=0xFFFFFFFF -> wready low while waiting; reg1=0xFF22FF44, bresp=00.
- Write to addr=0x40 (NUM_REGS=8) -> bresp=10, no register changes; read of 0x40 -> rresp=10, rdata=0.
- RO_MASK=8'h01, hw_status_i reg0=0x0000002A, write 0x1 to addr 0 -> bresp=10; read -> rdata=0x2A.
- bready_i held 0 for 4 cycles -> bvalid, bid and bresp stable; awready=wready=0 throughout; new AW accepted only after the response handshake.
- areset asserted while in RESP with bvalid=1 -> next cycle bvalid=0, all readies=1, regs=0.
